// File: rtl/counter_modulo_n_down_sync_pkg.sv
// Local types for the modulo-N down counter: the per-edge operation selected
// by the synchronous controls, and the helper that decodes it.
package counter_modulo_n_down_sync_pkg;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2
    } op_t;

    // Load outranks enable; the asynchronous clear never reaches this decode.
    function automatic op_t decode_op(input logic load_, input logic enable);
        if (!load_)
            return OP_LOAD;
        else if (enable)
            return OP_COUNT;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/counter_modulo_n_down_sync_if.sv
// Control and state bundle of one counter stage. The stage is the slave; its
// driver, or the previous stage in a cascade, is the master.
interface counter_modulo_n_down_sync_if #(
    parameter int WIDTH = 2
);
    logic             enable;
    logic             load_;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] signal_q;
    logic [WIDTH-1:0] signal_q_;
    logic             borrow;

    modport master (
        output enable, load_, data,
        input  signal_q, signal_q_, borrow
    );

    modport slave (
        input  enable, load_, data,
        output signal_q, signal_q_, borrow
    );
endinterface

// File: rtl/flip_flop_d_async.sv
// One-bit D flip-flop with asynchronous active-low clear and a complemented
// output, used as the state bit of the counter.
module flip_flop_d_async (
    input  logic clockpulse,
    input  logic clear_,
    input  logic d,
    output logic q,
    output logic q_
);

    // NOTE: clear_ sits in the sensitivity list so it acts with no clock edge;
    // state uses <= so every bit samples its D before any bit updates.
    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_)
            q <= 1'b0;
        else
            q <= d;
    end

    assign q_ = ~q;

endmodule

// File: rtl/counter_modulo_n_down_sync.sv
// Synchronous modulo-N down counter with parallel load, count enable and a
// combinational borrow for cascading. Counts MODULUS-1 down to 0, then wraps.
module counter_modulo_n_down_sync
    import counter_modulo_n_down_sync_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 4
) (
    input  logic                          clockpulse,
    input  logic                          clear_,
    counter_modulo_n_down_sync_if.slave   bus
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_n;
    logic [WIDTH-1:0] next_state;
    op_t              op;

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        op         = decode_op(bus.load_, bus.enable);
        unique case (op)
            OP_LOAD:  next_state = (bus.data > LAST) ? LAST : bus.data;
            // An out-of-range state (upset) recovers to LAST like a wrap.
            OP_COUNT: next_state = (state == '0 || state > LAST) ? LAST
                                                                 : state - 1'b1;
            default:  next_state = state;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        flip_flop_d_async u_ff (
            .clockpulse (clockpulse),
            .clear_     (clear_),
            .d          (next_state[i]),
            .q          (state[i]),
            .q_         (state_n[i])
        );
    end

    assign bus.signal_q  = state;
    assign bus.signal_q_ = state_n;
    assign bus.borrow    = clear_ & bus.load_ & bus.enable & (state == '0);

endmodule

// File: tb/tb_counter_modulo_n_down_sync.sv
// Bench for the modulo-N down counter: default, MODULUS=3, WIDTH=3/MODULUS=6
// and a two-stage cascade, checked against arithmetic reference models.
module tb_counter_modulo_n_down_sync;

    logic clockpulse = 1'b0;
    logic clear_;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: singles hold their count, the cascade holds s1*4+s0.
    int m_def, m_m3, m_w3, m_cas;

    counter_modulo_n_down_sync_if #(.WIDTH(2)) b_def ();
    counter_modulo_n_down_sync_if #(.WIDTH(2)) b_m3  ();
    counter_modulo_n_down_sync_if #(.WIDTH(3)) b_w3  ();
    counter_modulo_n_down_sync_if #(.WIDTH(2)) b_c0  ();
    counter_modulo_n_down_sync_if #(.WIDTH(2)) b_c1  ();

    assign b_c1.enable = b_c0.borrow;

    counter_modulo_n_down_sync #(.WIDTH(2), .MODULUS(4)) u_def (
        .clockpulse (clockpulse), .clear_ (clear_), .bus (b_def));
    counter_modulo_n_down_sync #(.WIDTH(2), .MODULUS(3)) u_m3 (
        .clockpulse (clockpulse), .clear_ (clear_), .bus (b_m3));
    counter_modulo_n_down_sync #(.WIDTH(3), .MODULUS(6)) u_w3 (
        .clockpulse (clockpulse), .clear_ (clear_), .bus (b_w3));
    counter_modulo_n_down_sync #(.WIDTH(2), .MODULUS(4)) u_c0 (
        .clockpulse (clockpulse), .clear_ (clear_), .bus (b_c0));
    counter_modulo_n_down_sync #(.WIDTH(2), .MODULUS(4)) u_c1 (
        .clockpulse (clockpulse), .clear_ (clear_), .bus (b_c1));

    always #5 clockpulse = ~clockpulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_next(input int q, input int modulus, input logic ld_,
                                    input logic en, input int data);
        if (!ld_)
            return (data > modulus - 1) ? modulus - 1 : data;
        if (en)
            return (q + modulus - 1) % modulus;
        return q;
    endfunction

    task automatic zero_models();
        m_def = 0; m_m3 = 0; m_w3 = 0; m_cas = 0;
    endtask

    task automatic check_state();
        check("def_q",  b_def.signal_q,  m_def);
        check("def_qn", b_def.signal_q_, 3 - m_def);
        check("m3_q",   b_m3.signal_q,   m_m3);
        check("m3_qn",  b_m3.signal_q_,  3 - m_m3);
        check("w3_q",   b_w3.signal_q,   m_w3);
        check("w3_qn",  b_w3.signal_q_,  7 - m_w3);
        check("c0_q",   b_c0.signal_q,   m_cas % 4);
        check("c1_q",   b_c1.signal_q,   m_cas / 4);
    endtask

    // Called just after a rising edge with new inputs in place: checks borrow
    // against the pre-edge state, takes one edge, then checks the new state.
    task automatic step();
        logic bw0;
        #1;
        bw0 = clear_ & b_c0.enable & ((m_cas % 4) == 0);
        check("def_borrow", b_def.borrow, clear_ & b_def.load_ & b_def.enable & (m_def == 0));
        check("m3_borrow",  b_m3.borrow,  clear_ & b_m3.load_ & b_m3.enable & (m_m3 == 0));
        check("w3_borrow",  b_w3.borrow,  clear_ & b_w3.load_ & b_w3.enable & (m_w3 == 0));
        check("c0_borrow",  b_c0.borrow,  bw0);
        check("c1_borrow",  b_c1.borrow,  bw0 & ((m_cas / 4) == 0));
        @(posedge clockpulse);
        if (!clear_) begin
            zero_models();
        end else begin
            m_def = ref_next(m_def, 4, b_def.load_, b_def.enable, int'(b_def.data));
            m_m3  = ref_next(m_m3,  3, b_m3.load_,  b_m3.enable,  int'(b_m3.data));
            m_w3  = ref_next(m_w3,  6, b_w3.load_,  b_w3.enable,  int'(b_w3.data));
            if (b_c0.enable)
                m_cas = (m_cas + 15) % 16;
        end
        #1;
        check_state();
    endtask

    initial begin
        clear_ = 1'b0;
        b_def.load_ = 1'b1; b_def.enable = 1'b1; b_def.data = '0;
        b_m3.load_  = 1'b1; b_m3.enable  = 1'b1; b_m3.data  = '0;
        b_w3.load_  = 1'b1; b_w3.enable  = 1'b1; b_w3.data  = '0;
        b_c0.load_  = 1'b1; b_c0.enable  = 1'b1; b_c0.data  = '0;
        b_c1.load_  = 1'b1;                      b_c1.data  = '0;
        zero_models();

        // Reset before any clock edge; enable is high so borrow must be masked.
        #3;
        check("rst_q",      b_def.signal_q,  0);
        check("rst_qn",     b_def.signal_q_, 3);
        check("rst_borrow", b_def.borrow,    0);
        check("rst_w3_qn",  b_w3.signal_q_,  7);
        check_state();

        b_def.enable = 1'b0; b_m3.enable = 1'b0; b_w3.enable = 1'b0; b_c0.enable = 1'b0;
        @(posedge clockpulse);
        #1;
        clear_ = 1'b1;
        repeat (3) step();
        check("rel_hold_q", b_def.signal_q, 0);

        // Count down from 0; the cascade needs 16 edges to come back to 00/00.
        b_def.enable = 1'b1; b_w3.enable = 1'b1; b_c0.enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 6)
                check("w3_wrap_q", b_w3.signal_q, 5);
        end
        check("count_final_q", b_def.signal_q, 1);
        check("cas_mid_c1_q", b_c1.signal_q, 0);
        b_def.enable = 1'b0; b_w3.enable = 1'b0;
        step();
        check("cas_final_c0", b_c0.signal_q, 0);
        check("cas_final_c1", b_c1.signal_q, 0);
        b_c0.enable = 1'b0;

        // Load beats enable; MODULUS=3 clamps an over-range load to 2.
        b_def.load_ = 1'b0; b_def.data = 2'd2; b_def.enable = 1'b0;
        b_m3.load_  = 1'b0; b_m3.data  = 2'd3; b_m3.enable  = 1'b1;
        step();
        check("load_q",  b_def.signal_q, 2);
        check("clamp_q", b_m3.signal_q,  2);
        b_def.load_ = 1'b1; b_m3.load_ = 1'b1; b_m3.enable = 1'b0;

        repeat (4) step();
        check("hold_q", b_def.signal_q, 2);

        // Clear dropped between edges acts at once.
        #3;
        clear_ = 1'b0;
        #1;
        check("midclr_q",      b_def.signal_q,  0);
        check("midclr_qn",     b_def.signal_q_, 3);
        check("midclr_borrow", b_def.borrow,    0);
        check("midclr_m3_q",   b_m3.signal_q,   0);
        zero_models();
        #2;
        clear_ = 1'b1;

        for (int i = 0; i < 300; i++) begin
            step();
            clear_       = ($urandom_range(0, 39) != 0);
            b_def.load_  = ($urandom_range(0, 3) != 0);
            b_def.enable = 1'($urandom);
            b_def.data   = 2'($urandom);
            b_m3.load_   = ($urandom_range(0, 3) != 0);
            b_m3.enable  = 1'($urandom);
            b_m3.data    = 2'($urandom);
            b_w3.load_   = ($urandom_range(0, 3) != 0);
            b_w3.enable  = 1'($urandom);
            b_w3.data    = 3'($urandom);
            b_c0.enable  = ($urandom_range(0, 3) != 0);
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
